rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Owns the single register-file write port; arbitrates between the pipeline writeback path (RegWriteW/RdW/ResultW) and results returning from a multi-cycle execution unit (divider/multiplier) via valid/ready.
- Holds a one-entry buffer for multi-cycle results and a 32-bit pending-destination scoreboard for the hazard unit.
- Requests a one-cycle pipeline freeze when a buffered result has been starved too long.

Parameters:
- XLEN, 32, data width
- STARVE_LIMIT, 4, cycles a buffered result may wait before a forced pipeline stall (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- RegWriteW  input  1  pipeline writeback enable
- RdW  input  5  pipeline destination
- ResultW  input  XLEN  pipeline writeback data
- mc_issue_valid  input  1  multi-cycle op issued this cycle
- mc_issue_rd  input  5  destination of issued op
- mc_valid  input  1  multi-cycle result valid
- mc_rd  input  5  result destination
- mc_data  input  XLEN  result data
- mc_ready  output  1  arbiter accepts result
- rs1_addr, rs2_addr  input  5 each  hazard lookup addresses
- rs1_busy, rs2_busy  output  1 each  lookup address has a pending multi-cycle write
- busy_vec  output  32  scoreboard, bit i = register i pending
- stall_req  output  1  registered freeze request to the hazard unit
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  XLEN  register-file write data

Behaviour:
- Reset (async, rst_n=0): state IDLE; buffer empty; wait_cnt=0; busy_vec=0; stall_req=0; mc_ready=1 after release. rf_we=0 whenever no source is selected.
- Handshake: a transfer occurs when mc_valid && mc_ready. mc_ready = !buf_valid, registered-state only. mc_ready has no combinational path from mc_valid.
- States:
  - IDLE: buffer empty.
  - HOLD: buffer valid; wait_cnt counts cycles not drained.
  - FORCE: stall_req=1; buffer is written this cycle.
- Write-port priority each cycle, combinational, first match wins:
  1. state FORCE → buffer.
  2. RegWriteW && RdW!=0 → pipeline.
  3. buf_valid → buffer.
  4. mc transfer → mc inputs directly; the result is not buffered.
- rd = 0:
  - Pipeline write with RdW=0 is not a request.
  - Multi-cycle result with rd=0 is accepted and discarded; rf_we=0 and it is never buffered.
- Transfers:
  - A transfer not written in its arrival cycle loads the buffer: IDLE→HOLD, wait_cnt=0.
- From HOLD:
  - Buffer drained this cycle → IDLE.
  - Else wait_cnt==STARVE_LIMIT-1 → FORCE.
  - Else wait_cnt++.
- From FORCE → IDLE unconditionally.
- Worst-case buffered latency: load cycle + STARVE_LIMIT + 1.
- During FORCE the pipeline inputs are ignored. The hazard unit holds MEM/WB, so the same pipeline write is re-presented next cycle and proceeds normally.
- Scoreboard:
  - mc_issue_valid && mc_issue_rd!=0 sets busy[mc_issue_rd].
  - A multi-cycle write to the register file (direct or from buffer) clears busy[rf_waddr].
  - Same-cycle set and clear on the same rd: set wins.
  - Bit 0 is always 0.
  - rsN_busy = busy_vec[rsN_addr], combinational on registered state.
- A pipeline write to a register with its busy bit set is a hazard-unit contract violation. The implementation carries a simulation assertion for it; no RTL recovery.
- Reset mid-operation discards the buffered result and clears all busy bits.

Decomposition:
- Add to pipeline_pkg:
  - state enum arb_state_t {IDLE, HOLD, FORCE}.
  - struct mc_result_t {rd[4:0], data[XLEN-1:0]}, used for the buffer entry.
  - WCNT_W = 4.
- One sub-module: wb_scoreboard, holding the 32-bit busy register, set/clear logic and the two lookup ports.
- Arbitration FSM, buffer and write mux stay in the top.

Test Plan:
- Idle result: reset, then mc_valid=1, mc_rd=5, mc_data=0xDEAD_BEEF, RegWriteW=0 → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; busy[5] cleared next cycle; buffer stays empty.
- Conflict: RegWriteW=1, RdW=3, ResultW=0x11 and mc result rd=7, data=0x22 in the same cycle → pipeline writes x3; x7 is buffered; mc_ready=0 next cycle; x7 is written the first cycle RegWriteW=0.
- Starvation: buffer loaded with rd=9, RegWriteW=1 held continuously, STARVE_LIMIT=4 → stall_req=1 exactly 5 cycles after load; in that cycle rf_waddr=9; stall_req=0 the following cycle; the pipeline write resumes.
- Scoreboard: issue rd=12, check rs1_addr=12 → rs1_busy=1; a result for x12 returns in the same cycle as a new issue to rd=12 → busy[12] stays 1.
- rd=0 cases: mc_issue_rd=0, then result rd=0 → busy_vec unchanged, rf_we=0, mc_ready=1. Pipeline RdW=0 with RegWriteW=1 does not block a direct mc write.
- Async reset: rst_n asserted while in HOLD with busy[4]=1 → immediately stall_req=0, rf_we=0, busy_vec=0; after release, mc_ready=1 and state is IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the register-file write arbiter.
//   RF_XLEN      : default data width of a buffered multi-cycle result
//   WCNT_W       : width of the starvation counter (holds STARVE_LIMIT up to 15)
//   arb_state_t  : arbitration FSM states
//   mc_result_t  : one buffered multi-cycle result (destination + data)
package pipeline_pkg;

    localparam int unsigned RF_XLEN = 32;
    localparam int unsigned WCNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [4:0]         rd;
        logic [RF_XLEN-1:0] data;
    } mc_result_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for multi-cycle operations.
//   clk, rst_n              : clock, async active-low reset
//   set_en_i / set_rd_i     : multi-cycle op issued, mark destination pending
//   clr_en_i / clr_rd_i     : multi-cycle result written, clear destination
//   rs1_addr_i / rs2_addr_i : hazard lookup addresses
//   rs1_busy_o / rs2_busy_o : lookup address has a pending write
//   busy_vec_o              : full scoreboard, bit i = register i pending
module wb_scoreboard
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_rd_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic [31:0] busy_vec_o
);

    logic [31:0] busy_q, busy_d;

    // Clear first so a same-cycle issue to the same register keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_en_i && (set_rd_i != 5'd0)) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Chooses each cycle between the pipeline writeback path and a returning
// multi-cycle result; a result that loses arbitration is parked in a one-entry
// buffer and, if starved for STARVE_LIMIT cycles, forces a one-cycle pipeline
// freeze so it can drain.
//   clk, rst_n                     : clock, async active-low reset
//   RegWriteW, RdW, ResultW        : pipeline writeback request
//   mc_issue_valid, mc_issue_rd    : multi-cycle op issue (scoreboard set)
//   mc_valid, mc_rd, mc_data       : multi-cycle result, handshaked by mc_ready
//   rs1_addr/rs2_addr -> rsN_busy  : hazard lookups; busy_vec is the scoreboard
//   stall_req                      : registered freeze request
//   rf_we, rf_waddr, rf_wdata      : the register-file write port
module rf_write_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            mc_issue_valid,
    input  logic [4:0]      mc_issue_rd,
    input  logic            mc_valid,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_data,
    output logic            mc_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [31:0]     busy_vec,
    output logic            stall_req,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam logic [WCNT_W-1:0] WaitMax = WCNT_W'(STARVE_LIMIT - 1);

    arb_state_t        state_q, state_d;
    mc_result_t        buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic pipe_req;
    logic mc_xfer;
    logic mc_write;   // current write comes from the multi-cycle side
    logic buf_drain;  // buffer is the selected source this cycle

    // Ready depends on registered state only, never on mc_valid.
    assign mc_ready = !buf_valid_q;
    assign mc_xfer  = mc_valid && mc_ready;
    assign pipe_req = RegWriteW && (RdW != 5'd0);

    // Freeze request is a decode of the state register, so it is glitch-free.
    assign stall_req = (state_q == FORCE);

    // Write-port mux, first match wins.
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = '0;
        mc_write  = 1'b0;
        buf_drain = 1'b0;
        if (state_q == FORCE) begin
            rf_we     = 1'b1;
            rf_waddr  = buf_q.rd;
            rf_wdata  = buf_q.data;
            mc_write  = 1'b1;
            buf_drain = 1'b1;
        end else if (pipe_req) begin
            rf_we    = 1'b1;
            rf_waddr = RdW;
            rf_wdata = ResultW;
        end else if (buf_valid_q) begin
            rf_we     = 1'b1;
            rf_waddr  = buf_q.rd;
            rf_wdata  = buf_q.data;
            mc_write  = 1'b1;
            buf_drain = 1'b1;
        end else if (mc_xfer && (mc_rd != 5'd0)) begin
            // rd=0 results are accepted above but fall through and are dropped.
            rf_we    = 1'b1;
            rf_waddr = mc_rd;
            rf_wdata = mc_data;
            mc_write = 1'b1;
        end
    end

    // Arbitration FSM and buffer next-state.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        wait_cnt_d  = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                // A transfer only happens with the buffer empty; it loses the
                // port only to a pipeline write.
                if (mc_xfer && (mc_rd != 5'd0) && pipe_req) begin
                    buf_d.rd    = mc_rd;
                    buf_d.data  = mc_data;
                    buf_valid_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (buf_drain) begin
                    buf_valid_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = IDLE;
                end else if (wait_cnt_q == WaitMax) begin
                    state_d = FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FORCE: begin
                buf_valid_d = 1'b0;
                wait_cnt_d  = '0;
                state_d     = IDLE;
            end
            default: begin
                buf_valid_d = 1'b0;
                wait_cnt_d  = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (mc_issue_valid),
        .set_rd_i   (mc_issue_rd),
        .clr_en_i   (rf_we && mc_write),
        .clr_rd_i   (rf_waddr),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .busy_vec_o (busy_vec)
    );

    // The hazard unit must never let a pipeline write hit a pending register.
    a_pipe_write_not_busy : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(pipe_req && (state_q != FORCE) && busy_vec[RdW])
    );

endmodule
